fp_subtractor_seq: RTL

- Multi-cycle IEEE-754 single-precision subtractor; computes diff = a - b.
- Companion to the team's combinational float adder, covering the opposite operation.
- Handles the hard part of subtraction, massive cancellation, with an iterative left-normalizer (one bit per cycle) behind a start/busy/done handshake.
- Sits beside the adder in the datapath; results truncate (no rounding), as the adder's do.

---
 rtl/fp_subtractor_seq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/fp_subtractor_seq.sv
// rtl/fp_subtractor_seq.sv - multi-cycle truncating single-precision subtractor (a - b)
// Optional FP_SUB_ADD_MODE_EN adds an op input: op=1 computes a + b instead.
module fp_subtractor_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
`ifdef FP_SUB_ADD_MODE_EN
  input  logic                   op,
`endif
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   zero,
  output logic                   ovf,
  output logic                   unf,
  output logic                   nan
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  typedef enum logic [2:0] {IDLE, ALIGN, ARITH, NORM, DONE} state_t;

  state_t             state, state_n;
  logic               s_x, s_y, s_x_n, s_y_n;
  logic [EXP_W-1:0]   e_x, e_y, e_x_n, e_y_n, e_inc, d;
  logic [MAN_W:0]     m_x, m_y, m_x_n, m_y_n;
  logic [MAN_W+1:0]   m, m_n;
  logic [W-1:0]       result_n;
  logic               zero_n, ovf_n, unf_n, nan_n;
  logic               b_sign_eff;

`ifdef FP_SUB_ADD_MODE_EN
  assign b_sign_eff = b[W-1] ^ ~op;
`else
  assign b_sign_eff = ~b[W-1];
`endif

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign e_inc = e_x + EXP_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      s_x    <= 1'b0;
      s_y    <= 1'b0;
      e_x    <= '0;
      e_y    <= '0;
      m_x    <= '0;
      m_y    <= '0;
      m      <= '0;
      result <= '0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      nan    <= 1'b0;
    end else begin
      state  <= state_n;
      s_x    <= s_x_n;
      s_y    <= s_y_n;
      e_x    <= e_x_n;
      e_y    <= e_y_n;
      m_x    <= m_x_n;
      m_y    <= m_y_n;
      m      <= m_n;
      result <= result_n;
      zero   <= zero_n;
      ovf    <= ovf_n;
      unf    <= unf_n;
      nan    <= nan_n;
    end
  end

  always_comb begin
    state_n  = state;
    s_x_n    = s_x;
    s_y_n    = s_y;
    e_x_n    = e_x;
    e_y_n    = e_y;
    m_x_n    = m_x;
    m_y_n    = m_y;
    m_n      = m;
    result_n = result;
    zero_n   = zero;
    ovf_n    = ovf;
    unf_n    = unf;
    nan_n    = nan;
    d        = '0;
    case (state)
      IDLE: begin
        if (start) begin
          s_x_n   = a[W-1];
          e_x_n   = a[W-2:MAN_W];
          m_x_n   = (a[W-2:MAN_W] == '0) ? '0 : {1'b1, a[MAN_W-1:0]};
          s_y_n   = b_sign_eff;
          e_y_n   = b[W-2:MAN_W];
          m_y_n   = (b[W-2:MAN_W] == '0) ? '0 : {1'b1, b[MAN_W-1:0]};
          state_n = ALIGN;
        end
      end
      ALIGN: begin
        if (e_x == EXP_MAX || e_y == EXP_MAX) begin
          result_n = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
          zero_n   = 1'b0;
          ovf_n    = 1'b0;
          unf_n    = 1'b0;
          nan_n    = 1'b1;
          state_n  = DONE;
        end else begin
          // X always ends up holding the larger magnitude, so mx-my never goes negative
          if ({e_y, m_y} > {e_x, m_x}) begin
            s_x_n = s_y;
            e_x_n = e_y;
            m_x_n = m_y;
            s_y_n = s_x;
            d     = e_y - e_x;
            m_y_n = (d >= EXP_W'(MAN_W + 1)) ? '0 : (m_x >> d);
          end else begin
            d     = e_x - e_y;
            m_y_n = (d >= EXP_W'(MAN_W + 1)) ? '0 : (m_y >> d);
          end
          state_n = ARITH;
        end
      end
      ARITH: begin
        m_n     = (s_x == s_y) ? ({1'b0, m_x} + {1'b0, m_y})
                               : ({1'b0, m_x} - {1'b0, m_y});
        state_n = NORM;
      end
      NORM: begin
        zero_n = 1'b0;
        ovf_n  = 1'b0;
        unf_n  = 1'b0;
        nan_n  = 1'b0;
        if (m == '0) begin
          result_n = '0;
          zero_n   = 1'b1;
          state_n  = DONE;
        end else if (m[MAN_W+1]) begin
          e_x_n = e_inc;
          m_n   = m >> 1;
          if (e_inc == EXP_MAX) begin
            result_n = {s_x, EXP_MAX, {MAN_W{1'b0}}};
            ovf_n    = 1'b1;
          end else begin
            result_n = {s_x, e_inc, m[MAN_W:1]};
          end
          state_n = DONE;
        end else if (m[MAN_W]) begin
          result_n = {s_x, e_x, m[MAN_W-1:0]};
          state_n  = DONE;
        end else if (e_x == EXP_W'(1)) begin
          result_n = {s_x, {(W-1){1'b0}}};
          zero_n   = 1'b1;
          unf_n    = 1'b1;
          state_n  = DONE;
        end else begin
          // flags are only committed on the cycle that enters DONE
          zero_n = zero;
          ovf_n  = ovf;
          unf_n  = unf;
          nan_n  = nan;
          m_n    = m << 1;
          e_x_n  = e_x - EXP_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
